// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle radix-2 restoring unsigned divider
module seq_divider #(
   parameter int DIVIDEND_W = 20,
   parameter int DIVISOR_W  = 12,
   parameter int ROUND      = 0
) (
   input  logic                  clk,
   input  logic                  sclr,
   input  logic                  en,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  busy,
   output logic                  done,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  div_by_zero
);

   localparam int CW = $clog2(DIVIDEND_W + 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t                state, nxt;
   logic [CW-1:0]         cnt;
   logic [DIVIDEND_W-1:0] dreg;
   logic [DIVISOR_W-1:0]  dvs;
   logic [DIVISOR_W:0]    part;

   logic [DIVISOR_W:0]    shifted;
   logic [DIVISOR_W+1:0]  trial;
   logic                  qbit;
   logic [DIVISOR_W:0]    part_n;
   logic [DIVIDEND_W-1:0] dreg_n;
   logic                  last;
   logic                  dvs_zero;
   logic                  round_up;

   // part stays below dvs, so its top bit never carries into the shift
   always_comb begin
      shifted  = {part[DIVISOR_W-1:0], dreg[DIVIDEND_W-1]};
      trial    = {1'b0, shifted} - {2'b00, dvs};
      qbit     = ~trial[DIVISOR_W+1];
      part_n   = qbit ? trial[DIVISOR_W:0] : shifted;
      dreg_n   = {dreg[DIVIDEND_W-2:0], qbit};
      last     = (cnt == CW'(1));
      dvs_zero = (dvs == '0);
      round_up = ({part, 1'b0} >= {2'b00, dvs}) && !(&dreg);
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE: if (start) nxt = RUN;
         RUN: begin
            if (dvs_zero)  nxt = DONE;
            else if (last) nxt = (ROUND != 0) ? FIX : DONE;
         end
         FIX:     nxt = DONE;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (sclr)    state <= IDLE;
      else if (en) state <= nxt;
   end

   // a zero divisor is detected on the first RUN edge, giving a one-edge latency
   always_ff @(posedge clk) begin
      if (sclr) begin
         cnt         <= '0;
         dreg        <= '0;
         dvs         <= '0;
         part        <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (en) begin
         case (state)
            IDLE: begin
               if (start) begin
                  dreg <= dividend;
                  dvs  <= divisor;
                  part <= '0;
                  cnt  <= CW'(DIVIDEND_W);
                  busy <= 1'b1;
               end
            end
            RUN: begin
               if (dvs_zero) begin
                  quotient    <= '1;
                  remainder   <= '0;
                  div_by_zero <= 1'b1;
                  busy        <= 1'b0;
                  done        <= 1'b1;
               end else begin
                  dreg <= dreg_n;
                  part <= part_n;
                  cnt  <= cnt - CW'(1);
                  if (last && ROUND == 0) begin
                     quotient    <= dreg_n;
                     remainder   <= part_n[DIVISOR_W-1:0];
                     div_by_zero <= 1'b0;
                     busy        <= 1'b0;
                     done        <= 1'b1;
                  end
               end
            end
            FIX: begin
               quotient    <= dreg + DIVIDEND_W'(round_up);
               remainder   <= part[DIVISOR_W-1:0];
               div_by_zero <= 1'b0;
               busy        <= 1'b0;
               done        <= 1'b1;
            end
            DONE:    done <= 1'b0;
            default: done <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider, truncating and rounding builds
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        sclr, en, start;
   logic [19:0] dividend;
   logic [11:0] divisor;
   logic        u0_busy, u0_done, u0_dbz, u1_busy, u1_done, u1_dbz;
   logic [19:0] u0_q, u1_q;
   logic [11:0] u0_r, u1_r;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_divider #(.DIVIDEND_W(20), .DIVISOR_W(12), .ROUND(0)) u0 (
      .clk(clk), .sclr(sclr), .en(en), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(u0_busy), .done(u0_done), .quotient(u0_q), .remainder(u0_r), .div_by_zero(u0_dbz));

   seq_divider #(.DIVIDEND_W(20), .DIVISOR_W(12), .ROUND(1)) u1 (
      .clk(clk), .sclr(sclr), .en(en), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(u1_busy), .done(u1_done), .quotient(u1_q), .remainder(u1_r), .div_by_zero(u1_dbz));

   typedef struct {
      logic [19:0] a;
      logic [11:0] b;
      int          q0;
      int          r;
      int          q1;
      int          z;
   } vec_t;

   vec_t tbl[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // reference: plain integer arithmetic
   task automatic model(input int a, input int b, input int rnd, output int q, output int r, output int z);
      if (b == 0) begin
         q = 20'hFFFFF; r = 0; z = 1;
      end else begin
         q = a / b; r = a % b; z = 0;
         if (rnd != 0 && 2 * r >= b && q != 20'hFFFFF) q = q + 1;
      end
   endtask

   task automatic run_div(input logic [19:0] a, input logic [11:0] b, input int eq0, input int er,
                          input int eq1, input int ez, input int hold_at, input bit poke);
      int lat0 = -1, lat1 = -1, exp0, exp1;
      logic [19:0] q0, q1;
      logic [11:0] r0, r1;
      logic z0, z1;
      bit bad = 0;
      exp0 = (ez != 0) ? 1 : 20;
      exp1 = (ez != 0) ? 1 : 21;
      if (hold_at > 0) begin exp0 += 5; exp1 += 5; end
      @(negedge clk);
      dividend = a; divisor = b; start = 1'b1;
      for (int i = 0; i < 80 && (lat0 < 0 || lat1 < 0); i++) begin
         @(negedge clk);
         if (i == 0) begin
            start = 1'b0; dividend = 20'($urandom); divisor = 12'($urandom);
         end
         if (poke && i == 3) begin start = 1'b1; dividend = 20'd77; divisor = 12'd5; end
         if (poke && i == 4) start = 1'b0;
         if (hold_at > 0 && i == hold_at) en = 1'b0;
         if (hold_at > 0 && i == hold_at + 5) en = 1'b1;
         if (lat0 < 0) begin
            if (u0_done) begin
               lat0 = i; q0 = u0_q; r0 = u0_r; z0 = u0_dbz;
               if (u0_busy) bad = 1;
            end else if (!u0_busy) bad = 1;
         end else if (i == lat0 + 1 && u0_done) bad = 1;
         if (lat1 < 0) begin
            if (u1_done) begin
               lat1 = i; q1 = u1_q; r1 = u1_r; z1 = u1_dbz;
               if (u1_busy) bad = 1;
            end else if (!u1_busy) bad = 1;
         end
      end
      @(negedge clk);
      check("idle_after", {28'd0, u0_busy, u0_done, u1_busy, u1_done}, 32'd0);
      check("lat_trunc", lat0, exp0);
      check("q_trunc", q0, eq0);
      check("r_trunc", r0, er);
      check("dbz_trunc", z0, ez);
      check("lat_round", lat1, exp1);
      check("q_round", q1, eq1);
      check("r_round", r1, er);
      check("dbz_round", z1, ez);
      check("busy_done_shape", bad, 0);
   endtask

   initial begin
      int q0, q1, r, z, rr, zz, hold;
      logic [19:0] a;
      logic [11:0] b;
      bit bad;

      tbl[0] = '{20'd1000,    12'd7,    142,     6,   143,     0};
      tbl[1] = '{20'd1000,    12'd8,    125,     0,   125,     0};
      tbl[2] = '{20'd9,       12'd6,    1,       3,   2,       0};
      tbl[3] = '{20'd1048575, 12'd1,    1048575, 0,   1048575, 0};
      tbl[4] = '{20'd1048575, 12'd4095, 256,     255, 256,     0};
      tbl[5] = '{20'd5,       12'd4095, 0,       5,   0,       0};
      tbl[6] = '{20'd0,       12'd9,    0,       0,   0,       0};
      tbl[7] = '{20'd1048575, 12'd2,    524287,  1,   524288,  0};
      tbl[8] = '{20'd500,     12'd0,    1048575, 0,   1048575, 1};
      tbl[9] = '{20'd10,      12'd3,    3,       1,   3,       0};

      sclr = 1'b1; en = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(negedge clk);
      check("reset_trunc", {u0_busy, u0_done, u0_dbz, u0_q, u0_r}, 32'd0);
      check("reset_round", {u1_busy, u1_done, u1_dbz, u1_q, u1_r}, 32'd0);
      sclr = 1'b0;

      for (int k = 0; k < 10; k++)
         run_div(tbl[k].a, tbl[k].b, tbl[k].q0, tbl[k].r, tbl[k].q1, tbl[k].z, 0, 1'b0);

      run_div(20'd1048575, 12'd4095, 256, 255, 256, 0, 5, 1'b0);
      run_div(20'd1000, 12'd7, 142, 6, 143, 0, 0, 1'b1);

      // abort mid-run; outputs from the previous division must be wiped
      @(negedge clk);
      dividend = 20'd1000; divisor = 12'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      sclr = 1'b1;
      @(negedge clk);
      check("sclr_trunc", {u0_busy, u0_done, u0_dbz, u0_q, u0_r}, 32'd0);
      check("sclr_round", {u1_busy, u1_done, u1_dbz, u1_q, u1_r}, 32'd0);
      sclr = 1'b0;
      bad = 0;
      repeat (30) begin
         @(negedge clk);
         if (u0_done || u1_done || u0_busy || u1_busy) bad = 1;
      end
      check("sclr_no_done", bad, 0);
      run_div(20'd1000, 12'd7, 142, 6, 143, 0, 0, 1'b0);

      for (int k = 0; k < 30; k++) begin
         a = 20'($urandom_range(0, 20'hFFFFF));
         b = (k % 5 == 0) ? 12'd0 : ((k % 3 == 0) ? 12'($urandom_range(1, 15)) : 12'($urandom_range(1, 4095)));
         model(int'(a), int'(b), 0, q0, r, z);
         model(int'(a), int'(b), 1, q1, rr, zz);
         hold = (b != 0 && k % 7 == 3) ? int'($urandom_range(2, 10)) : 0;
         run_div(a, b, q0, r, q1, z, hold, (b != 0 && k % 4 == 1));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
